vect_fir_sequencer: RTL

//  Sequences the M-lane vector ALU through one FIR output block: per tap, fetch sample/coef vectors,

---
 rtl/vect_fir_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/vect_fir_sequencer.sv
// vect_fir_sequencer
//   Drives an external combinational M-lane vector ALU through one FIR output block.
//   For each tap k it reads sample/coef vectors at base+k, issues MULI, and accumulates
//   the sign-extended lane products. When all taps are done it issues an arithmetic
//   right shift of the reduced accumulators and holds the result until it is accepted.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   start, abort                     job request (IDLE only) / synchronous kill
//   cfg_taps, cfg_shift              tap count 1..TAPS_MAX, output right shift
//   cfg_smp_base, cfg_coef_base      memory base addresses
//   mem_rd_en, smp_addr, coef_addr   read strobe and addresses (data returns next cycle)
//   smp_rdata, coef_rdata            vectors read from memory (lane i = [i*N +: N])
//   alu_a, alu_b, alu_ctrl           ALU operands and opcode
//   alu_result, alu_flags            ALU result and {neg,zero,carry,ovf} per lane
//   busy, cfg_err                    job in flight / rejected-start pulse
//   out_valid, out_ready             output handshake
//   out_data, out_carry              scaled vector, per-lane sticky MULI carry
//
// Build option
//   VSEQ_SAT_EN  when defined, accumulators are clamped to the signed N-bit range before
//                the shift; otherwise the low N bits are used (two's-complement wrap).

module vect_fir_sequencer #(
    parameter int unsigned N        = 8,
    parameter int unsigned M        = 4,
    parameter int unsigned TAPS_MAX = 16,
    parameter int unsigned AW       = 8,
    parameter int unsigned ACC_W    = N + 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    input  logic [4:0]     cfg_taps,
    input  logic [2:0]     cfg_shift,
    input  logic [AW-1:0]  cfg_smp_base,
    input  logic [AW-1:0]  cfg_coef_base,
    output logic           mem_rd_en,
    output logic [AW-1:0]  smp_addr,
    output logic [AW-1:0]  coef_addr,
    input  logic [M*N-1:0] smp_rdata,
    input  logic [M*N-1:0] coef_rdata,
    output logic [M*N-1:0] alu_a,
    output logic [M*N-1:0] alu_b,
    output logic [3:0]     alu_ctrl,
    input  logic [M*N-1:0] alu_result,
    input  logic [4*M-1:0] alu_flags,
    output logic           busy,
    output logic           cfg_err,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [M*N-1:0] out_data,
    output logic [M-1:0]   out_carry
);

    localparam logic [3:0]       OpIdle  = 4'b0000;
    localparam logic [3:0]       OpMuli  = 4'b0010;
    localparam logic [3:0]       OpAsr   = 4'b0011;
    localparam logic [4:0]       TapsMax = 5'(TAPS_MAX);
    localparam logic signed [ACC_W-1:0] SatMax = ACC_W'((1 << (N - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SatMin = ~SatMax;

    typedef enum logic [2:0] {StIdle, StRd, StMul, StScale, StOut} state_e;

    state_e                    state_q;
    logic [4:0]                taps_q;
    logic [2:0]                shift_q;
    logic [AW-1:0]             smp_base_q;
    logic [AW-1:0]             coef_base_q;
    logic [4:0]                k_q;
    logic signed [ACC_W-1:0]   acc_q [M];
    logic [M-1:0]              carry_q;

    // Narrow an accumulator to an N-bit ALU operand.
    function automatic logic [N-1:0] reduce(input logic signed [ACC_W-1:0] a);
`ifdef VSEQ_SAT_EN
        if (a > SatMax) begin
            return SatMax[N-1:0];
        end else if (a < SatMin) begin
            return SatMin[N-1:0];
        end
        return a[N-1:0];
`else
        return a[N-1:0];
`endif
    endfunction

    // Memory and ALU controls decode straight from the state register; the ALU is
    // combinational, so its result is consumed in the same cycle the op is issued.
    always_comb begin
        mem_rd_en = 1'b0;
        smp_addr  = '0;
        coef_addr = '0;
        alu_a     = '0;
        alu_b     = '0;
        alu_ctrl  = OpIdle;
        case (state_q)
            StRd: begin
                mem_rd_en = 1'b1;
                smp_addr  = smp_base_q + AW'(k_q);
                coef_addr = coef_base_q + AW'(k_q);
            end
            StMul: begin
                alu_a    = smp_rdata;
                alu_b    = coef_rdata;
                alu_ctrl = OpMuli;
            end
            StScale: begin
                for (int i = 0; i < M; i++) begin
                    alu_a[i*N +: N] = reduce(acc_q[i]);
                    alu_b[i*N +: N] = N'(shift_q);
                end
                alu_ctrl = OpAsr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            taps_q      <= '0;
            shift_q     <= '0;
            smp_base_q  <= '0;
            coef_base_q <= '0;
            k_q         <= '0;
            carry_q     <= '0;
            for (int i = 0; i < M; i++) acc_q[i] <= '0;
            busy        <= 1'b0;
            cfg_err     <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_carry   <= '0;
        end else begin
            cfg_err <= 1'b0;
            if (abort && state_q != StIdle) begin
                // Kill wins over everything, including a same-cycle output transfer.
                state_q   <= StIdle;
                busy      <= 1'b0;
                out_valid <= 1'b0;
                k_q       <= '0;
                carry_q   <= '0;
                for (int i = 0; i < M; i++) acc_q[i] <= '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start) begin
                            if (cfg_taps != 5'd0 && cfg_taps <= TapsMax) begin
                                taps_q      <= cfg_taps;
                                shift_q     <= cfg_shift;
                                smp_base_q  <= cfg_smp_base;
                                coef_base_q <= cfg_coef_base;
                                k_q         <= '0;
                                carry_q     <= '0;
                                for (int i = 0; i < M; i++) acc_q[i] <= '0;
                                busy        <= 1'b1;
                                state_q     <= StRd;
                            end else begin
                                cfg_err <= 1'b1;
                            end
                        end
                    end
                    StRd: state_q <= StMul;
                    StMul: begin
                        for (int i = 0; i < M; i++) begin
                            acc_q[i] <= acc_q[i] +
                                {{(ACC_W-N){alu_result[i*N+N-1]}}, alu_result[i*N +: N]};
                            carry_q[i] <= carry_q[i] | alu_flags[4*i+1];
                        end
                        k_q     <= k_q + 5'd1;
                        state_q <= (k_q == taps_q - 5'd1) ? StScale : StRd;
                    end
                    StScale: begin
                        out_data  <= alu_result;
                        out_carry <= carry_q;
                        out_valid <= 1'b1;
                        state_q   <= StOut;
                    end
                    StOut: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            state_q   <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule
